// File: rtl/mem_if.sv
// mem_if: request/response handshake between the core's memory port and the responder.
// With MEM_BYTE_EN defined, the request also carries per-byte write enables.
interface mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef MEM_BYTE_EN
  logic [3:0]  req_be;
`endif
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
`ifdef MEM_BYTE_EN
    output req_be,
`endif
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
`ifdef MEM_BYTE_EN
    input  req_be,
`endif
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed unified memory with a fixed-latency response.
// Define MEM_BYTE_EN to enable byte-masked writes via req_be.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  mem_if.slave bus,
  output logic busy_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("mem_responder: LATENCY must be in 1..15");
  end

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              addr_err;
  logic              accept;
  logic              commit;

  assign idx      = addr_q[ADDR_W+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) | (|addr_q[31:ADDR_W+2]);
  assign accept   = (state_q == IDLE) & req_ready_q & bus.req_valid;
  assign commit   = (state_q == WAIT) & (cnt_q == 4'd0);

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign busy_o         = busy_q;

`ifdef MEM_BYTE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      be_q <= 4'h0;
    end else if (accept) begin
      be_q <= bus.req_be;
    end
  end
`else
  assign be_q = 4'hF;
`endif

  // Storage is not reset; a write commits on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (commit && we_q && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= CNT_INIT;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= addr_err;
            rdata_q      <= (we_q || addr_err) ? 32'd0 : mem[idx];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random transfers against three latency builds,
// checked against an array-based memory model.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  int sel = 1;
  bit keep_valid = 1'b0;
  bit chk_space = 1'b0;
  int last_acc = 0;

  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        resp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'hF;

  mem_if b1 ();
  mem_if b2 ();
  mem_if b4 ();
  logic bz1, bz2, bz4;

  assign b1.req_valid  = req_valid && (sel == 0);
  assign b2.req_valid  = req_valid && (sel == 1);
  assign b4.req_valid  = req_valid && (sel == 2);
  assign b1.resp_ready = resp_ready && (sel == 0);
  assign b2.resp_ready = resp_ready && (sel == 1);
  assign b4.resp_ready = resp_ready && (sel == 2);
  assign b1.req_we = req_we;
  assign b2.req_we = req_we;
  assign b4.req_we = req_we;
  assign b1.req_addr = req_addr;
  assign b2.req_addr = req_addr;
  assign b4.req_addr = req_addr;
  assign b1.req_wdata = req_wdata;
  assign b2.req_wdata = req_wdata;
  assign b4.req_wdata = req_wdata;
`ifdef MEM_BYTE_EN
  assign b1.req_be = req_be;
  assign b2.req_be = req_be;
  assign b4.req_be = req_be;
`endif

  mem_responder #(.ADDR_W(8), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .busy_o(bz1));
  mem_responder #(.ADDR_W(8), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave), .busy_o(bz2));
  mem_responder #(.ADDR_W(8), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave), .busy_o(bz4));

  logic        rr, rv, re, bsy;
  logic [31:0] rd;
  assign rr  = (sel == 0) ? b1.req_ready  : (sel == 1) ? b2.req_ready  : b4.req_ready;
  assign rv  = (sel == 0) ? b1.resp_valid : (sel == 1) ? b2.resp_valid : b4.resp_valid;
  assign re  = (sel == 0) ? b1.resp_err   : (sel == 1) ? b2.resp_err   : b4.resp_err;
  assign rd  = (sel == 0) ? b1.resp_rdata : (sel == 1) ? b2.resp_rdata : b4.resp_rdata;
  assign bsy = (sel == 0) ? bz1 : (sel == 1) ? bz2 : bz4;

  logic [31:0] mdl   [3][256];
  bit          known [3][256];

  function automatic int lat_of(int s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int bp);
    int          n;
    int          acc;
    int          idx;
    int          lat;
    bit          exp_e;
    bit          dchk;
    logic [3:0]  ebe;
    logic [31:0] exp_d;
    logic [31:0] r0;
    lat = lat_of(sel);
`ifdef MEM_BYTE_EN
    ebe = be;
`else
    ebe = 4'hF;
`endif
    exp_e = (a[1:0] != 2'b00) || (a >= 32'd1024);
    idx   = int'(a[9:2]);
    dchk  = we || exp_e || known[sel][idx];
    exp_d = (we || exp_e) ? 32'd0 : mdl[sel][idx];
    if (we && !exp_e) begin
      for (int i = 0; i < 4; i++)
        if (ebe[i]) mdl[sel][idx][8*i +: 8] = d[8*i +: 8];
      if (ebe == 4'hF) known[sel][idx] = 1'b1;
    end

    n = 0;
    while (rr !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", rr, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = d;
    req_be     = be;
    resp_ready = (bp == 0);
    @(negedge clk);
    acc = cyc;
    if (!keep_valid) req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    chk("busy_after_accept", bsy, 1);
    chk("req_ready_after_accept", rr, 0);
    if (chk_space) chk("accept_spacing", acc - last_acc, lat + 2);
    last_acc = acc;

    n = 0;
    while (rv !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", cyc - acc, lat);
    if (dchk) chk("rdata", rd, exp_d);
    chk("err", re, exp_e);
    r0 = rd;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("hold_valid", rv, 1);
      chk("hold_rdata", rd, r0);
      chk("hold_req_ready", rr, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", rv, 0);
    chk("release_err", re, 0);
    chk("release_req_ready", rr, 1);
    chk("release_busy", bsy, 0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;

    sel = 1;
    #12;
    chk("rst_req_ready", rr, 0);
    chk("rst_resp_valid", rv, 0);
    chk("rst_rdata", rd, 0);
    chk("rst_err", re, 0);
    chk("rst_busy", bsy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_first_edge", rr, 1);

    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 0);
    chk("read_back_const", rd, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 5);
    xfer(1'b1, 32'h13, 32'h1, 4'hF, 0);
    xfer(1'b1, 32'h400, 32'h1, 4'hF, 0);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 0);

`ifdef MEM_BYTE_EN
    xfer(1'b1, 32'h30, 32'hAABBCCDD, 4'hF, 0);
    xfer(1'b1, 32'h30, 32'h11223344, 4'b0101, 0);
    xfer(1'b0, 32'h30, 32'h0, 4'hF, 0);
    chk("byte_en_const", mdl[1][12], 32'hAA22CC44);
`endif

    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 9));
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 1) a = a | 32'h400;
      if (r == 2) a = a | 32'h8000_0000;
      xfer(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    sel = 2;
    @(negedge clk);
    xfer(1'b1, 32'h20, 32'hCAFE0001, 4'hF, 0);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    req_be     = 4'hF;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_busy", bsy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", rr, 0);
    chk("midrst_resp_valid", rv, 0);
    chk("midrst_rdata", rd, 0);
    chk("midrst_err", re, 0);
    chk("midrst_busy", bsy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready_release", rr, 1);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 0);

    sel = 0;
    @(negedge clk);
    for (int k = 0; k < 8; k++)
      xfer(1'b1, 32'h40 + 32'(4 * k), $urandom, 4'hF, 0);
    keep_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_space = (k > 0);
      xfer(1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'hF, 0);
    end
    keep_valid = 1'b0;
    chk_space  = 1'b0;
    req_valid  = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
